hud_lives: RTL

Lives heads-up display for the shooting game. Holds the player's life count and updates it on life-lost and life-gain events. Scans the 15x15 heart sprite ROM in step with the VGA pixel counters to draw one heart per remaining life in the top-left HUD strip. A heart that was just lost blinks for a programmable number of frames. Sits between the game-logic block (events) and the pixel mixer (hud_pixel).

---
 rtl/hud_lives_pkg.sv | 27 ++
 rtl/hud_lives_if.sv | 34 +++
 rtl/hud_lives_ctrl.sv | 90 +++++++++
 rtl/hud_lives.sv | 93 +++++++++
 4 files changed

// File: rtl/hud_lives_pkg.sv
// Shared game constants and types for the lives HUD.
// Latency: n/a (types only). Backpressure: n/a.
// Heart sprite is 15x15 on a fixed 16 px pitch; coordinates are 10-bit.
package hud_lives_pkg;

    localparam int HEART_W     = 15;
    localparam int HEART_PITCH = 16;
    localparam int COORD_W     = 10;
    localparam int LIVES_W     = 3;
    localparam int BLINK_W     = 8;
    localparam int SLOT_W      = COORD_W - $clog2(HEART_PITCH);

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [LIVES_W-1:0] lives_t;
    typedef logic [SLOT_W-1:0]  slot_t;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic       en;
    } spr_req_t;

    function automatic slot_t heart_slot(input coord_t dx);
        return dx[COORD_W-1:$clog2(HEART_PITCH)];
    endfunction

endpackage

// File: rtl/hud_lives_if.sv
// Pixel, event, sprite-ROM and HUD output bundle of the lives HUD.
// Latency: n/a (wiring only). Backpressure: none, all signals are strobes/levels.
// master = game/video/ROM side, slave = hud_lives.
interface hud_lives_if;

    hud_lives_pkg::coord_t pix_x;
    hud_lives_pkg::coord_t pix_y;
    logic                  pix_valid;
    logic                  frame_start;
    logic                  life_lost;
    logic                  life_gain;
    logic                  game_reset;
    logic [3:0]            spr_x;
    logic [3:0]            spr_y;
    logic                  spr_en;
    logic                  spr_data;
    logic                  hud_pixel;
    logic                  hud_valid;
    hud_lives_pkg::lives_t lives;
    logic                  game_over;

    modport master (
        output pix_x, pix_y, pix_valid, frame_start,
        output life_lost, life_gain, game_reset, spr_data,
        input  spr_x, spr_y, spr_en, hud_pixel, hud_valid, lives, game_over
    );

    modport slave (
        input  pix_x, pix_y, pix_valid, frame_start,
        input  life_lost, life_gain, game_reset, spr_data,
        output spr_x, spr_y, spr_en, hud_pixel, hud_valid, lives, game_over
    );

endinterface

// File: rtl/hud_lives_ctrl.sv
// Life counter with event priority, frame-latched display count and lost-heart blink (HUD_LIVES_BLINK_EN).
// Latency: lives 1 clk after an event; disp_lives follows at the next frame_start.
// Backpressure: none, every event is consumed in the cycle it arrives.
module hud_lives_ctrl
    import hud_lives_pkg::*;
#(
    parameter int MAX_LIVES    = 5,
    parameter int INIT_LIVES   = 3,
    parameter int BLINK_FRAMES = 16
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   frame_start,
    input  logic   life_lost,
    input  logic   life_gain,
    input  logic   game_reset,
    output lives_t lives,
    output lives_t disp_lives,
    output logic   game_over,
    output logic   blink_vis
);

    if (MAX_LIVES < 1 || MAX_LIVES > 7 || INIT_LIVES < 0 || INIT_LIVES > MAX_LIVES ||
        BLINK_FRAMES < 1 || BLINK_FRAMES > 255) begin : g_param_check
        $error("hud_lives_ctrl: parameter out of range");
    end

    lives_t lives_q;
    lives_t lives_nxt;
    lives_t disp_q;

    always_comb begin
        lives_nxt = lives_q;
        if (game_reset) begin
            lives_nxt = lives_t'(INIT_LIVES);
        end else if (life_lost && life_gain) begin
            lives_nxt = lives_q;
        end else if (life_lost) begin
            if (lives_q != '0) begin
                lives_nxt = lives_q - 1'b1;
            end
        end else if (life_gain) begin
            if (lives_q < lives_t'(MAX_LIVES)) begin
                lives_nxt = lives_q + 1'b1;
            end
        end
    end

    // disp_lives samples the pre-event count, so an event on a frame_start shows one frame later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lives_q <= lives_t'(INIT_LIVES);
            disp_q  <= lives_t'(INIT_LIVES);
        end else begin
            lives_q <= lives_nxt;
            if (frame_start) begin
                disp_q <= lives_q;
            end
        end
    end

`ifdef HUD_LIVES_BLINK_EN
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_load;

    assign blink_load = !game_reset && life_lost && !life_gain && (lives_q != '0);

    // a reload beats the frame decrement so a repeated loss restarts the full blink
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
        end else if (game_reset) begin
            blink_cnt <= '0;
        end else if (blink_load) begin
            blink_cnt <= BLINK_W'(BLINK_FRAMES);
        end else if (frame_start && blink_cnt != '0) begin
            blink_cnt <= blink_cnt - 1'b1;
        end
    end

    assign blink_vis = (blink_cnt != '0) && blink_cnt[1];
`else
    assign blink_vis = 1'b0;
`endif

    assign lives      = lives_q;
    assign disp_lives = disp_q;
    assign game_over  = (lives_q == '0);

endmodule

// File: rtl/hud_lives.sv
// Lives HUD: draws one 15x15 heart per remaining life from the sprite ROM (blink option: HUD_LIVES_BLINK_EN).
// Latency: 2 clk from pix_x/pix_y/pix_valid to hud_pixel/hud_valid.
// Backpressure: none, follows the pixel stream every cycle.
module hud_lives
    import hud_lives_pkg::*;
#(
    parameter int MAX_LIVES    = 5,
    parameter int INIT_LIVES   = 3,
    parameter int HUD_X0       = 8,
    parameter int HUD_Y0       = 8,
    parameter int BLINK_FRAMES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    hud_lives_if.slave  bus
);

    lives_t disp_lives;
    logic   blink_vis;

    hud_lives_ctrl #(
        .MAX_LIVES    (MAX_LIVES),
        .INIT_LIVES   (INIT_LIVES),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (bus.frame_start),
        .life_lost   (bus.life_lost),
        .life_gain   (bus.life_gain),
        .game_reset  (bus.game_reset),
        .lives       (bus.lives),
        .disp_lives  (disp_lives),
        .game_over   (bus.game_over),
        .blink_vis   (blink_vis)
    );

    coord_t   dx;
    coord_t   dy;
    slot_t    slot;
    logic     in_strip;
    logic     drawn;
    spr_req_t s1_nxt;
    spr_req_t s1_q;
    logic     hud_valid_d1;
    logic     hud_pixel_q;
    logic     hud_valid_q;

    assign dx   = bus.pix_x - coord_t'(HUD_X0);
    assign dy   = bus.pix_y - coord_t'(HUD_Y0);
    assign slot = heart_slot(dx);

    // column 15 of each 16 px cell is the inter-heart gap
    assign in_strip = (bus.pix_x >= coord_t'(HUD_X0)) &&
                      (bus.pix_y >= coord_t'(HUD_Y0)) &&
                      (dy < coord_t'(HEART_W)) &&
                      (slot < slot_t'(MAX_LIVES)) &&
                      (dx[3:0] < 4'(HEART_W));

    assign drawn = in_strip &&
                   ((slot < slot_t'(disp_lives)) ||
                    ((slot == slot_t'(disp_lives)) && blink_vis));

    always_comb begin
        s1_nxt    = '0;
        s1_nxt.en = drawn && bus.pix_valid;
        if (s1_nxt.en) begin
            s1_nxt.x = dx[3:0];
            s1_nxt.y = dy[3:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q         <= '0;
            hud_valid_d1 <= 1'b0;
            hud_pixel_q  <= 1'b0;
            hud_valid_q  <= 1'b0;
        end else begin
            s1_q         <= s1_nxt;
            hud_valid_d1 <= bus.pix_valid;
            hud_pixel_q  <= bus.spr_data && s1_q.en;
            hud_valid_q  <= hud_valid_d1;
        end
    end

    assign bus.spr_x     = s1_q.x;
    assign bus.spr_y     = s1_q.y;
    assign bus.spr_en    = s1_q.en;
    assign bus.hud_pixel = hud_pixel_q;
    assign bus.hud_valid = hud_valid_q;

endmodule
